// File: rtl/psg_mixer_pkg.sv
// Shared types and constants for the PSG time-multiplexed stereo mixer.
package psg_mixer_pkg;

  typedef enum logic [1:0] {
    PAN_MUTE = 2'b00,
    PAN_L    = 2'b01,
    PAN_R    = 2'b10,
    PAN_BOTH = 2'b11
  } pan_t;

  typedef struct packed {
    pan_t       pan;
    logic [1:0] rsvd;
    logic [3:0] gain;
  } ch_cfg_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } mixer_state_t;

  localparam logic [3:0] STATUS_ADDR = 4'hF;
  localparam logic [3:0] PEAK_L_ADDR = 4'hD;
  localparam logic [3:0] PEAK_R_ADDR = 4'hE;

  // Legacy routing: channels of even PSGs go left, odd PSGs go right, full gain.
  function automatic ch_cfg_t reset_cfg(input int k);
    ch_cfg_t c;
    c.pan  = (((k / 3) % 2) == 0) ? PAN_L : PAN_R;
    c.rsvd = 2'b00;
    c.gain = 4'hF;
    return c;
  endfunction

endpackage

// File: rtl/psg_tdm_mixer_if.sv
// Configuration bus between the card's I/O decode and the mixer register file.
interface psg_tdm_mixer_if;
  logic       cfg_we_i;
  logic [3:0] cfg_addr_i;
  logic [7:0] cfg_wdata_i;
  logic [7:0] cfg_rdata_o;

  modport master (output cfg_we_i, cfg_addr_i, cfg_wdata_i, input cfg_rdata_o);
  modport slave  (input cfg_we_i, cfg_addr_i, cfg_wdata_i, output cfg_rdata_o);
endinterface

// File: rtl/psg_mixer_cfg_regs.sv
// Mixer register file: per-channel pan/gain, status/overrun and read mux.
// Peak-hold meters are built only when PSG_TDM_MIXER_PEAK_METER_EN is defined.
module psg_mixer_cfg_regs
  import psg_mixer_pkg::*;
#(
  parameter int NUM_CH    = 12,
  parameter int SUM_W     = 12,
  parameter int OUT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 srst,
  psg_tdm_mixer_if.slave       cfg,
  input  logic                 busy_i,
  input  logic                 overrun_set_i,
  input  logic                 peak_upd_i,
  input  logic [SUM_W-1:0]     peak_l_i,
  input  logic [SUM_W-1:0]     peak_r_i,
  output ch_cfg_t [NUM_CH-1:0] ch_cfg_o,
  output logic                 overrun_o
);

  ch_cfg_t [NUM_CH-1:0] ch_cfg_q, ch_cfg_d;
  logic                 overrun_q, overrun_d;
  logic [7:0]           peak_l_rd, peak_r_rd;
  logic [1:0]           wdata_rsvd_unused;

  assign wdata_rsvd_unused = cfg.cfg_wdata_i[5:4];

  always_comb begin
    ch_cfg_d = ch_cfg_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cfg.cfg_we_i && (cfg.cfg_addr_i == 4'(k))) begin
        ch_cfg_d[k].pan  = pan_t'(cfg.cfg_wdata_i[7:6]);
        ch_cfg_d[k].rsvd = 2'b00;
        ch_cfg_d[k].gain = cfg.cfg_wdata_i[3:0];
      end
    end
  end

  // Set is applied last so a new overrun is never lost to a same-cycle clear.
  always_comb begin
    overrun_d = overrun_q;
    if (cfg.cfg_we_i && (cfg.cfg_addr_i == STATUS_ADDR)) overrun_d = 1'b0;
    if (overrun_set_i) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int k = 0; k < NUM_CH; k++) ch_cfg_q[k] <= reset_cfg(k);
      overrun_q <= 1'b0;
    end else begin
      ch_cfg_q  <= ch_cfg_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef PSG_TDM_MIXER_PEAK_METER_EN
  logic [SUM_W-1:0] peak_l_q, peak_l_d, peak_r_q, peak_r_d;
  logic             clr_l, clr_r;

  // The I/O decode presents a peak address for a single cycle per CPU read.
  assign clr_l = (cfg.cfg_addr_i == PEAK_L_ADDR);
  assign clr_r = (cfg.cfg_addr_i == PEAK_R_ADDR);

  always_comb begin
    peak_l_d = clr_l ? '0 : peak_l_q;
    peak_r_d = clr_r ? '0 : peak_r_q;
    if (peak_upd_i) begin
      if (clr_l || (peak_l_i > peak_l_q)) peak_l_d = peak_l_i;
      if (clr_r || (peak_r_i > peak_r_q)) peak_r_d = peak_r_i;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      peak_l_q <= '0;
      peak_r_q <= '0;
    end else begin
      peak_l_q <= peak_l_d;
      peak_r_q <= peak_r_d;
    end
  end

  assign peak_l_rd = 8'(peak_l_q >> (OUT_WIDTH - 8));
  assign peak_r_rd = 8'(peak_r_q >> (OUT_WIDTH - 8));
`else
  logic peak_unused;
  assign peak_unused = ^{peak_upd_i, peak_l_i, peak_r_i};
  assign peak_l_rd   = 8'h00;
  assign peak_r_rd   = 8'h00;
`endif

  always_comb begin
    cfg.cfg_rdata_o = 8'h00;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cfg.cfg_addr_i == 4'(k)) cfg.cfg_rdata_o = ch_cfg_q[k];
    end
    if (cfg.cfg_addr_i == STATUS_ADDR) cfg.cfg_rdata_o = {6'b0, busy_i, overrun_q};
    if (cfg.cfg_addr_i == PEAK_L_ADDR) cfg.cfg_rdata_o = peak_l_rd;
    if (cfg.cfg_addr_i == PEAK_R_ADDR) cfg.cfg_rdata_o = peak_r_rd;
  end

  assign ch_cfg_o  = ch_cfg_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/psg_tdm_mixer.sv
// Time-multiplexed stereo mixer for NUM_PSG YM2149s: one channel per clock into L/R accumulators.
// Define PSG_TDM_MIXER_PEAK_METER_EN to add peak-hold meters at addresses 0xD/0xE.
module psg_tdm_mixer
  import psg_mixer_pkg::*;
#(
  parameter int NUM_PSG    = 4,
  parameter int CH_WIDTH   = 8,
  parameter int GAIN_WIDTH = 4,
  parameter int OUT_WIDTH  = 12
) (
  input  logic                            clk_logic,
  input  logic                            system_reset,
  input  logic                            sample_strobe_i,
  input  logic [3*NUM_PSG*CH_WIDTH-1:0]   ch_level_i,
  psg_tdm_mixer_if.slave                  cfg,
  output logic [OUT_WIDTH-1:0]            audio_l_o,
  output logic [OUT_WIDTH-1:0]            audio_r_o,
  output logic                            sample_valid_o,
  output logic                            busy_o,
  output logic                            overrun_o
);

  localparam int NUM_CH = 3 * NUM_PSG;
  localparam int IDX_W  = $clog2(NUM_CH);
  localparam int ACC_W  = CH_WIDTH + GAIN_WIDTH + IDX_W;
  localparam int SUM_W  = ACC_W - GAIN_WIDTH;

  mixer_state_t                 state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [NUM_CH*CH_WIDTH-1:0]   snap_q, snap_d;
  logic [ACC_W-1:0]             acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [OUT_WIDTH-1:0]         audio_l_q, audio_l_d, audio_r_q, audio_r_d;
  logic                         valid_q, valid_d;

  ch_cfg_t [NUM_CH-1:0]         ch_cfg;
  ch_cfg_t                      cur_cfg;
  logic [1:0]                   cur_rsvd_unused;
  logic [CH_WIDTH-1:0]          cur_level;
  logic [ACC_W-1:0]             term;
  logic [SUM_W-1:0]             sum_l, sum_r;
  logic                         busy, overrun_set;

  function automatic logic [OUT_WIDTH-1:0] sat(input logic [SUM_W-1:0] s);
    logic [SUM_W+OUT_WIDTH-1:0] wide;
    wide = (SUM_W + OUT_WIDTH)'(s);
    if (wide > (SUM_W + OUT_WIDTH)'({OUT_WIDTH{1'b1}})) return '1;
    return OUT_WIDTH'(s);
  endfunction

  // Levels come from the snapshot; pan/gain are read live so mid-mix writes hit pending channels.
  assign cur_cfg         = ch_cfg[idx_q];
  assign cur_rsvd_unused = cur_cfg.rsvd;
  assign cur_level       = snap_q[idx_q*CH_WIDTH +: CH_WIDTH];
  assign term            = ACC_W'(cur_level) * ACC_W'(cur_cfg.gain);
  assign sum_l           = acc_l_q[ACC_W-1:GAIN_WIDTH];
  assign sum_r           = acc_r_q[ACC_W-1:GAIN_WIDTH];

  assign busy        = (state_q != IDLE) || valid_q;
  assign overrun_set = sample_strobe_i && busy;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    audio_l_d = audio_l_q;
    audio_r_d = audio_r_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_strobe_i && !valid_q) begin
          snap_d  = ch_level_i;
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (cur_cfg.pan[0]) acc_l_d = acc_l_q + term;
        if (cur_cfg.pan[1]) acc_r_d = acc_r_q + term;
        if (idx_q == IDX_W'(NUM_CH - 1)) state_d = DONE;
        else                             idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        audio_l_d = sat(sum_l);
        audio_r_d = sat(sum_r);
        valid_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_logic) begin
    if (system_reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      snap_q    <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      audio_l_q <= '0;
      audio_r_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      audio_l_q <= audio_l_d;
      audio_r_q <= audio_r_d;
      valid_q   <= valid_d;
    end
  end

  psg_mixer_cfg_regs #(
    .NUM_CH    (NUM_CH),
    .SUM_W     (SUM_W),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_cfg_regs (
    .clk           (clk_logic),
    .srst          (system_reset),
    .cfg           (cfg),
    .busy_i        (busy),
    .overrun_set_i (overrun_set),
    .peak_upd_i    (state_q == DONE),
    .peak_l_i      (sum_l),
    .peak_r_i      (sum_r),
    .ch_cfg_o      (ch_cfg),
    .overrun_o     (overrun_o)
  );

  assign audio_l_o      = audio_l_q;
  assign audio_r_o      = audio_r_q;
  assign sample_valid_o = valid_q;
  assign busy_o         = busy;

endmodule

// File: tb/tb_psg_tdm_mixer.sv
// Self-checking bench for psg_tdm_mixer: directed steps plus randomized mixes against a sum model.
module tb_psg_tdm_mixer;
  localparam int NUM_PSG    = 2;
  localparam int CH_WIDTH   = 8;
  localparam int GAIN_WIDTH = 4;
  localparam int OUT_WIDTH  = 10;
  localparam int NUM_CH     = 3 * NUM_PSG;
  localparam int OUT_MAX    = (1 << OUT_WIDTH) - 1;

  logic                          clk_logic = 1'b0;
  logic                          system_reset = 1'b1;
  logic                          sample_strobe_i = 1'b0;
  logic [NUM_CH*CH_WIDTH-1:0]    ch_level_i = '0;
  logic [OUT_WIDTH-1:0]          audio_l_o, audio_r_o;
  logic                          sample_valid_o, busy_o, overrun_o;

  psg_tdm_mixer_if cfg_if ();

  psg_tdm_mixer #(
    .NUM_PSG    (NUM_PSG),
    .CH_WIDTH   (CH_WIDTH),
    .GAIN_WIDTH (GAIN_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) dut (
    .clk_logic       (clk_logic),
    .system_reset    (system_reset),
    .sample_strobe_i (sample_strobe_i),
    .ch_level_i      (ch_level_i),
    .cfg             (cfg_if),
    .audio_l_o       (audio_l_o),
    .audio_r_o       (audio_r_o),
    .sample_valid_o  (sample_valid_o),
    .busy_o          (busy_o),
    .overrun_o       (overrun_o)
  );

  always #5 clk_logic = ~clk_logic;

  int total = 0;
  int bad   = 0;
  int m_pan [NUM_CH];
  int m_gain[NUM_CH];
  int lv    [NUM_CH];

  int         lat, pulses, e_l, e_r, s_l, s_r, ch;
  logic [7:0] rd, wd;

  task automatic tick();
    @(posedge clk_logic);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_pan[k]  = (((k / 3) % 2) == 0) ? 1 : 2;
      m_gain[k] = 15;
    end
  endtask

  // Reference: each panned side is sum(level*gain) / 2^GAIN_WIDTH, clipped at full scale.
  task automatic model_mix(output int l, output int r, output int sl, output int sr);
    sl = 0;
    sr = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if ((m_pan[k] & 1) != 0) sl += lv[k] * m_gain[k];
      if ((m_pan[k] & 2) != 0) sr += lv[k] * m_gain[k];
    end
    sl = sl / (1 << GAIN_WIDTH);
    sr = sr / (1 << GAIN_WIDTH);
    l  = (sl > OUT_MAX) ? OUT_MAX : sl;
    r  = (sr > OUT_MAX) ? OUT_MAX : sr;
  endtask

  task automatic apply_levels();
    for (int k = 0; k < NUM_CH; k++) ch_level_i[k*CH_WIDTH +: CH_WIDTH] = 8'(lv[k]);
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [7:0] data);
    cfg_if.cfg_we_i    = 1'b1;
    cfg_if.cfg_addr_i  = addr;
    cfg_if.cfg_wdata_i = data;
    tick();
    cfg_if.cfg_we_i    = 1'b0;
    cfg_if.cfg_addr_i  = 4'h0;
    if (int'(addr) < NUM_CH) begin
      m_pan[addr]  = int'(data[7:6]);
      m_gain[addr] = int'(data[3:0]);
    end
  endtask

  task automatic cfg_read(input logic [3:0] addr, output logic [7:0] v);
    cfg_if.cfg_addr_i = addr;
    #1;
    v = cfg_if.cfg_rdata_o;
    tick();
    cfg_if.cfg_addr_i = 4'h0;
  endtask

  task automatic run_mix(output int latency, output int npulse);
    sample_strobe_i = 1'b1;
    latency = -1;
    npulse  = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 1) begin
        sample_strobe_i = 1'b0;
        chk("busy_after_strobe", busy_o, 1);
      end
      if (sample_valid_o) begin
        npulse++;
        if (latency < 0) latency = n;
        chk("busy_in_valid_cycle", busy_o, 1);
      end
    end
    chk("busy_idle_after_mix", busy_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    cfg_if.cfg_we_i    = 1'b0;
    cfg_if.cfg_addr_i  = 4'h0;
    cfg_if.cfg_wdata_i = 8'h00;
    model_reset();
    #1;
    tick(); tick(); tick();
    system_reset = 1'b0;

    // Reset state
    chk("rst_audio_l", audio_l_o, 0);
    chk("rst_audio_r", audio_r_o, 0);
    chk("rst_valid", sample_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_overrun", overrun_o, 0);
    cfg_read(4'hF, rd); chk("rst_status", rd, 8'h00);
    cfg_read(4'h0, rd); chk("rst_ch0", rd, 8'h4F);
    cfg_read(4'h3, rd); chk("rst_ch3", rd, 8'h8F);

    // Legacy mix, full scale levels
    for (int k = 0; k < NUM_CH; k++) lv[k] = 255;
    apply_levels();
    run_mix(lat, pulses);
    chk("legacy_latency", lat, NUM_CH + 2);
    chk("legacy_pulses", pulses, 1);
    chk("legacy_l", audio_l_o, 717);
    chk("legacy_r", audio_r_o, 717);

    // Single channel routed to both sides at gain 8
    cfg_write(4'h0, 8'hC8);
    for (int k = 1; k < NUM_CH; k++) cfg_write(4'(k), 8'h40);
    lv[0] = 128;
    for (int k = 1; k < NUM_CH; k++) lv[k] = $urandom_range(0, 255);
    apply_levels();
    run_mix(lat, pulses);
    chk("single_l", audio_l_o, 64);
    chk("single_r", audio_r_o, 64);

    // Everything on both sides: clips at full scale
    for (int k = 0; k < NUM_CH; k++) begin
      cfg_write(4'(k), 8'hCF);
      lv[k] = 255;
    end
    apply_levels();
    model_mix(e_l, e_r, s_l, s_r);
    run_mix(lat, pulses);
    chk("sat_l", audio_l_o, OUT_MAX);
    chk("sat_r", audio_r_o, OUT_MAX);
`ifdef PSG_TDM_MIXER_PEAK_METER_EN
    cfg_read(4'hD, rd); chk("peak_l", rd, (s_l >> (OUT_WIDTH - 8)) & 255);
    cfg_read(4'hE, rd); chk("peak_r", rd, (s_r >> (OUT_WIDTH - 8)) & 255);
    cfg_read(4'hD, rd); chk("peak_l_cleared", rd, 8'h00);
`else
    cfg_read(4'hD, rd); chk("peak_l_absent", rd, 8'h00);
    cfg_read(4'hE, rd); chk("peak_r_absent", rd, 8'h00);
`endif

    // Unmapped address: write ignored, reads zero
    cfg_write(4'h7, 8'hFF);
    cfg_read(4'h7, rd); chk("unmapped_7", rd, 8'h00);
    cfg_read(4'hC, rd); chk("unmapped_c", rd, 8'h00);

    // Second strobe while busy is dropped and flagged
    sample_strobe_i = 1'b1;
    tick();
    sample_strobe_i = 1'b0;
    tick(); tick();
    sample_strobe_i = 1'b1;
    tick();
    sample_strobe_i = 1'b0;
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (sample_valid_o) pulses++;
    end
    chk("overrun_pulses", pulses, 1);
    chk("overrun_flag", overrun_o, 1);
    cfg_read(4'hF, rd); chk("overrun_status", rd, 8'h01);
    cfg_write(4'hF, 8'($urandom_range(0, 255)));
    chk("overrun_cleared", overrun_o, 0);

    // Clear write coinciding with a new overrun: the overrun stays set
    sample_strobe_i = 1'b1;
    tick();
    cfg_if.cfg_we_i   = 1'b1;
    cfg_if.cfg_addr_i = 4'hF;
    tick();
    sample_strobe_i   = 1'b0;
    cfg_if.cfg_we_i   = 1'b0;
    cfg_if.cfg_addr_i = 4'h0;
    chk("overrun_set_wins", overrun_o, 1);
    for (int n = 0; n < 15; n++) tick();
    cfg_write(4'hF, 8'h00);
    chk("overrun_cleared2", overrun_o, 0);

    // Randomized mixes against the model
    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < 3; w++) begin
        ch = $urandom_range(0, NUM_CH - 1);
        cfg_write(4'(ch), 8'($urandom_range(0, 255)));
      end
      for (int k = 0; k < NUM_CH; k++) lv[k] = $urandom_range(0, 255);
      apply_levels();
      model_mix(e_l, e_r, s_l, s_r);
      run_mix(lat, pulses);
      chk("rand_latency", lat, NUM_CH + 2);
      chk("rand_pulses", pulses, 1);
      chk("rand_l", audio_l_o, e_l);
      chk("rand_r", audio_r_o, e_r);
      ch = $urandom_range(0, NUM_CH - 1);
      cfg_read(4'(ch), rd);
      chk("rand_readback", rd, (m_pan[ch] << 6) | m_gain[ch]);
    end

    // Mid-mix writes: pending ch5 picks up mute, already-summed ch0 keeps old value
    for (int k = 0; k < NUM_CH; k++) begin
      cfg_write(4'(k), 8'hCF);
      lv[k] = $urandom_range(1, 255);
    end
    apply_levels();
    m_pan[5] = 0;
    model_mix(e_l, e_r, s_l, s_r);
    sample_strobe_i = 1'b1;
    tick();
    sample_strobe_i = 1'b0;
    tick();
    wd = 8'(m_gain[5]);
    cfg_write(4'h5, wd);
    cfg_write(4'h0, 8'h43);
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (sample_valid_o) pulses++;
    end
    chk("midwrite_pulses", pulses, 1);
    chk("midwrite_l", audio_l_o, e_l);
    chk("midwrite_r", audio_r_o, e_r);
    model_mix(e_l, e_r, s_l, s_r);
    run_mix(lat, pulses);
    chk("next_l", audio_l_o, e_l);
    chk("next_r", audio_r_o, e_r);

    // Reset in the middle of accumulation
    sample_strobe_i = 1'b1;
    tick();
    sample_strobe_i = 1'b0;
    tick(); tick();
    system_reset = 1'b1;
    tick();
    system_reset = 1'b0;
    model_reset();
    chk("midrst_busy", busy_o, 0);
    chk("midrst_l", audio_l_o, 0);
    chk("midrst_r", audio_r_o, 0);
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (sample_valid_o) pulses++;
    end
    chk("midrst_no_valid", pulses, 0);
    cfg_read(4'h0, rd); chk("midrst_ch0", rd, 8'h4F);
    cfg_read(4'h5, rd); chk("midrst_ch5", rd, 8'h8F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
